// File: rtl/csr_tap_sampler.sv
// csr_tap_sampler: captures timestamped CSR tap snapshots on change or on request,
// queues them, and streams each one out as a 7-beat 32-bit record.
`default_nettype none

module csr_tap_sampler #(
  parameter int DEPTH    = 4,
  parameter int TS_WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        force_sample,
  input  logic        flag0,
  input  logic        flag1,
  input  logic        flag2,
  input  logic        flag3,
  input  logic        flag4,
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  input  logic [31:0] word2,
  input  logic [31:0] word3,
  input  logic [31:0] word4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    BEAT0 = 3'd0,
    BEAT1 = 3'd1,
    BEAT2 = 3'd2,
    BEAT3 = 3'd3,
    BEAT4 = 3'd4,
    BEAT5 = 3'd5,
    BEAT6 = 3'd6
  } state_t;

  state_t state, state_next;

  logic [4:0]        flags_in;
  logic [4:0][31:0]  words_in;
  logic [4:0]        last_flags;
  logic [4:0][31:0]  last_words;
  logic [9:0]        change_mask;

  logic [TS_WIDTH-1:0] ts;
  logic [15:0]         seq;
  logic                drop_pending;

  logic [9:0]          mem_mask  [DEPTH];
  logic [4:0]          mem_flags [DEPTH];
  logic [4:0][31:0]    mem_words [DEPTH];
  logic [TS_WIDTH-1:0] mem_ts    [DEPTH];
  logic                mem_drop  [DEPTH];
  logic [15:0]         mem_seq   [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full;
  logic          req, pop, accept, drop;
  logic [31:0]   head_header, head_ts;
  logic [4:0][31:0] head_words;

  assign flags_in = {flag4, flag3, flag2, flag1, flag0};
  assign words_in = {word4, word3, word2, word1, word0};

  always_comb begin
    change_mask = '0;
    for (int i = 0; i < 5; i++) begin
      change_mask[i]     = flags_in[i] != last_flags[i];
      change_mask[5 + i] = words_in[i] != last_words[i];
    end
  end

  assign empty  = (count == '0);
  assign full   = (count == (AW + 1)'(DEPTH));
  assign req    = enable && ((change_mask != '0) || force_sample);
  assign pop    = out_valid && out_ready && (state == BEAT6);
  // A record finishing this cycle frees its slot, so a request while full still fits.
  assign accept = req && (!full || pop);
  assign drop   = req && !accept;

  assign out_valid   = !empty;
  assign head_header = {mem_mask[rd_ptr], mem_flags[rd_ptr], mem_drop[rd_ptr], mem_seq[rd_ptr]};
  assign head_ts     = 32'(mem_ts[rd_ptr]);
  assign head_words  = mem_words[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= BEAT0;
      ts           <= '0;
      seq          <= '0;
      drop_pending <= 1'b0;
      drop_count   <= '0;
      last_flags   <= '0;
      last_words   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      state <= state_next;
      ts    <= ts + TS_WIDTH'(1);
      if (accept) begin
        last_flags   <= flags_in;
        last_words   <= words_in;
        seq          <= seq + 16'd1;
        drop_pending <= 1'b0;
        wr_ptr       <= wr_ptr + AW'(1);
      end
      if (drop) begin
        drop_pending <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem_mask[wr_ptr]  <= change_mask;
      mem_flags[wr_ptr] <= flags_in;
      mem_words[wr_ptr] <= words_in;
      mem_ts[wr_ptr]    <= ts;
      mem_drop[wr_ptr]  <= drop_pending;
      mem_seq[wr_ptr]   <= seq;
    end
  end

  always_comb begin
    state_next = state;
    out_data   = '0;
    out_last   = 1'b0;
    if (out_valid) begin
      case (state)
        BEAT0:   out_data = head_header;
        BEAT1:   out_data = head_ts;
        BEAT2:   out_data = head_words[0];
        BEAT3:   out_data = head_words[1];
        BEAT4:   out_data = head_words[2];
        BEAT5:   out_data = head_words[3];
        BEAT6: begin
          out_data = head_words[4];
          out_last = 1'b1;
        end
        default: out_data = '0;
      endcase
      if (out_ready) begin
        state_next = (state == BEAT6) ? BEAT0 : state_t'(state + 3'd1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csr_tap_sampler.sv
// Scoreboard bench for csr_tap_sampler: stimulus pushes expected beats, a monitor pops on handshakes.
`default_nettype none

module tb_csr_tap_sampler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        force_sample;
  logic        out_ready;
  logic [4:0]  flags_drv;
  logic [31:0] words_drv [5];
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic [15:0] drop_count;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q [$];
  logic [32:0] exp_beat;
  int unsigned cyc;

  always #5 clock = ~clock;

  csr_tap_sampler #(.DEPTH(4), .TS_WIDTH(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .force_sample (force_sample),
    .flag0        (flags_drv[0]),
    .flag1        (flags_drv[1]),
    .flag2        (flags_drv[2]),
    .flag3        (flags_drv[3]),
    .flag4        (flags_drv[4]),
    .word0        (words_drv[0]),
    .word1        (words_drv[1]),
    .word2        (words_drv[2]),
    .word3        (words_drv[3]),
    .word4        (words_drv[4]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .drop_count   (drop_count)
  );

  // Cycles since reset release: the timestamp a capture at the next edge should carry.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: got last=%0b data=0x%08h, expected no beat", out_last, out_data);
      end else begin
        exp_beat = exp_q.pop_front();
        if ({out_last, out_data} !== exp_beat) begin
          errors++;
          $display("FAIL beat: got last=%0b data=0x%08h, expected last=%0b data=0x%08h",
                   out_last, out_data, exp_beat[32], exp_beat[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic expect_record(input logic [9:0] mask, input logic drop,
                               input logic [15:0] seq, input logic [31:0] ts);
    exp_q.push_back({1'b0, mask, flags_drv, drop, seq});
    exp_q.push_back({1'b0, ts});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, words_drv[i]});
    exp_q.push_back({1'b1, words_drv[4]});
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    enable       = 1'b1;
    force_sample = 1'b0;
    out_ready    = 1'b0;
    flags_drv    = '0;
    for (int i = 0; i < 5; i++) words_drv[i] = '0;
    exp_q.delete();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_cyc(input int unsigned target);
    for (int i = 0; i < 50 && cyc != target; i++) step();
    check("wait_cyc", cyc, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values and idle behaviour.
    do_reset();
    reset_n = 1'b0;
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_last", out_last, 0);
    check("reset_drop", drop_count, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_valid", out_valid, 0);
    end
    check("idle_drop", drop_count, 0);

    // Single word change captured at ts=5.
    do_reset();
    out_ready = 1'b1;
    wait_cyc(5);
    words_drv[2] = 32'hDEADBEEF;
    expect_record(10'h080, 1'b0, 16'd0, 32'd5);
    step();
    wait_drain("single_drain");

    // Overflow: flag0 differs from the frozen reference on both overflow cycles.
    do_reset();
    begin
      logic vals [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
        flags_drv[0] = vals[i];
        if (i < 4) expect_record(10'h001, 1'b0, 16'(i), cyc);
        step();
      end
    end
    flags_drv[0] = 1'b0;
    step();
    check("ovf_drop", drop_count, 2);
    check("ovf_valid", out_valid, 1);
    check("ovf_head", out_data, 32'h00420000);
    out_ready = 1'b1;
    wait_drain("ovf_drain");
    flags_drv[1] = 1'b1;
    expect_record(10'h002, 1'b1, 16'd4, cyc);
    step();
    wait_drain("ovf_next_drain");
    check("ovf_drop_hold", drop_count, 2);

    // Forced samples with unchanged inputs.
    do_reset();
    out_ready    = 1'b1;
    force_sample = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_record(10'h000, 1'b0, 16'(i), cyc);
      step();
    end
    force_sample = 1'b0;
    wait_drain("force_drain");

    // Full FIFO with a change arriving on the BEAT6 handshake.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      flags_drv[i] = 1'b1;
      expect_record(10'h001 << i, 1'b0, 16'(i), cyc);
      step();
    end
    check("full_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("at_beat6_last", out_last, 1);
    flags_drv[4] = 1'b1;
    expect_record(10'h010, 1'b0, 16'd4, cyc);
    step();
    check("bypass_drop", drop_count, 0);
    out_ready    = 1'b0;
    words_drv[0] = 32'h1;
    step();
    check("still_full_drop", drop_count, 1);
    words_drv[0] = 32'h0;
    out_ready    = 1'b1;
    wait_drain("bypass_drain");

    // Reset in the middle of a record.
    do_reset();
    out_ready    = 1'b1;
    words_drv[1] = 32'h12345678;
    expect_record(10'h040, 1'b0, 16'd0, cyc);
    step();
    for (int i = 0; i < 3; i++) step();
    check("beat3_data", out_data, 32'h12345678);
    reset_n = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_data", out_data, 0);
    do_reset();
    out_ready = 1'b1;
    wait_cyc(3);
    flags_drv[2] = 1'b1;
    expect_record(10'h004, 1'b0, 16'd0, 32'd3);
    step();
    wait_drain("post_reset_drain");

    check("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
